// File: rtl/regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port, r0 hard-wired to zero.
// Latency: reads are combinational; writes commit on the rising clock edge, status outputs follow one cycle later.
// No backpressure: every write is accepted. Optional write-through forwarding is enabled by REGFILE_BYPASS_EN.
module regfile_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STATUS_REG = 30
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    input  logic                  ctrl_statusClear,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic [DATA_WIDTH-1:0] data_status,
    output logic                  status_event,
    output logic                  status_sticky
);

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(STATUS_REG);

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic                  r_status_event;
    logic                  r_status_sticky;

    logic                  w_wr_vld;
    logic                  w_status_wr;

    // Index 0 is architecturally zero, so writes to it are dropped here.
    assign w_wr_vld    = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign w_status_wr = ctrl_writeEnable && (ctrl_writeReg == STATUS_IDX);

    // Register storage: asynchronous clear of every entry, single write port.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_vld) begin
            r_regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Status tracking: one-cycle event pulse; sticky flag where a new write beats a clear.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_status_event  <= 1'b0;
            r_status_sticky <= 1'b0;
        end else begin
            r_status_event <= w_status_wr;
            if (w_status_wr) begin
                r_status_sticky <= 1'b1;
            end else if (ctrl_statusClear) begin
                r_status_sticky <= 1'b0;
            end
        end
    end

    // Read ports: stored value with r0 forced to zero, optionally forwarding the in-flight write.
    always_comb begin
        data_readRegA = (ctrl_readRegA == '0) ? '0 : r_regs[ctrl_readRegA];
        data_readRegB = (ctrl_readRegB == '0) ? '0 : r_regs[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by reset so nothing leaks out while the file is being cleared.
        if (ctrl_reset_n && w_wr_vld && (ctrl_readRegA == ctrl_writeReg)) begin
            data_readRegA = data_writeReg;
        end
        if (ctrl_reset_n && w_wr_vld && (ctrl_readRegB == ctrl_writeReg)) begin
            data_readRegB = data_writeReg;
        end
`endif
    end

    // Status outputs always show committed state, never the in-flight write.
    assign data_status   = r_regs[STATUS_IDX];
    assign status_event  = r_status_event;
    assign status_sticky = r_status_sticky;

endmodule
